// File: rtl/ncl_fulladd_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ncl_fulladd_sequencer_if                                         |
// | Brief    : Dual-rail four-phase handshake bundle between sequencer and adder|
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ncl_fulladd_sequencer_if;
    logic [1:0] A;
    logic [1:0] B;
    logic [1:0] carryin;
    logic       ABCOMP;
    logic       carryinCOMP;
    logic [1:0] sum;
    logic [1:0] carryout;
    logic       sumCOMP;
    logic       carryCOMP;

    modport master (
        output A, B, carryin, sumCOMP, carryCOMP,
        input  ABCOMP, carryinCOMP, sum, carryout
    );

    modport slave (
        input  A, B, carryin, sumCOMP, carryCOMP,
        output ABCOMP, carryinCOMP, sum, carryout
    );
endinterface
`default_nettype wire

// File: rtl/ncl_fulladd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ncl_fulladd_sequencer                                            |
// | Brief    : Bit-serial clocked driver/receiver for a dual-rail NCL full adder|
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module ncl_fulladd_sequencer #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  wire logic             clk,
    input  wire logic             init,
    input  wire logic             start,
    input  wire logic [WIDTH-1:0] a_in,
    input  wire logic [WIDTH-1:0] b_in,
    input  wire logic             cin,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      sum_out,
    output logic                  cout_out,
    output logic                  error,
    ncl_fulladd_sequencer_if.master ncl
);

    localparam int c_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT  = c_CNT_W'(TIMEOUT);
    localparam logic [1:0] c_RAIL_NULL = 2'b00;
    localparam logic [1:0] c_RAIL_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_NULL  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    function automatic logic [1:0] enc(input logic bit_v);
        return bit_v ? 2'b10 : 2'b01;
    endfunction

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [c_IDX_W-1:0]   idx_q, idx_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 c_q, c_d, cout_q, cout_d;
    logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [1:0]           rail_a_q, rail_a_d, rail_b_q, rail_b_d, rail_c_q, rail_c_d;
    logic                 scomp_q, scomp_d, ccomp_q, ccomp_d;

    // Bit order in each synchronizer word: {ABCOMP, carryinCOMP, sum, carryout}
    logic [SYNC_STAGES-1:0][5:0] sync_q;
    logic [5:0] w_ncl_raw;
    logic       w_ab_ack, w_ci_ack, w_illegal, w_timeout, w_data_done, w_null_done;
    logic [1:0] w_sum, w_cout;
    logic [c_IDX_W-1:0] w_idx_nxt;

    assign w_ncl_raw = {ncl.ABCOMP, ncl.carryinCOMP, ncl.sum, ncl.carryout};
    assign w_ab_ack  = sync_q[SYNC_STAGES-1][5];
    assign w_ci_ack  = sync_q[SYNC_STAGES-1][4];
    assign w_sum     = sync_q[SYNC_STAGES-1][3:2];
    assign w_cout    = sync_q[SYNC_STAGES-1][1:0];

    assign w_illegal   = (w_sum == c_RAIL_ILL) || (w_cout == c_RAIL_ILL);
    assign w_timeout   = (cnt_q == c_TIMEOUT);
    assign w_data_done = w_ab_ack && w_ci_ack && (w_sum != c_RAIL_NULL) && (w_cout != c_RAIL_NULL);
    assign w_null_done = !w_ab_ack && !w_ci_ack && (w_sum == c_RAIL_NULL) && (w_cout == c_RAIL_NULL);
    assign w_idx_nxt   = idx_q + c_IDX_W'(1);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        idx_d    = idx_q;
        c_d      = c_q;
        cout_d   = cout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        rail_a_d = rail_a_q;
        rail_b_d = rail_b_q;
        rail_c_d = rail_c_q;
        scomp_d  = scomp_q;
        ccomp_d  = ccomp_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a_in;
                    b_d      = b_in;
                    sum_d    = '0;
                    idx_d    = '0;
                    c_d      = cin;
                    busy_d   = 1'b1;
                    rail_a_d = enc(a_in[0]);
                    rail_b_d = enc(b_in[0]);
                    rail_c_d = enc(cin);
                    scomp_d  = 1'b0;
                    ccomp_d  = 1'b0;
                    state_d  = S_DATA;
                end
            end
            S_DATA, S_NULL: begin
                // A corrupt rail or a stalled phase beats any completion seen this cycle
                if (w_illegal || w_timeout) begin
                    err_d    = 1'b1;
                    busy_d   = 1'b0;
                    rail_a_d = c_RAIL_NULL;
                    rail_b_d = c_RAIL_NULL;
                    rail_c_d = c_RAIL_NULL;
                    scomp_d  = 1'b1;
                    ccomp_d  = 1'b1;
                    state_d  = S_ERROR;
                end else if (state_q == S_DATA) begin
                    if (w_data_done) begin
                        sum_d[idx_q] = w_sum[1];
                        c_d          = w_cout[1];
                        rail_a_d     = c_RAIL_NULL;
                        rail_b_d     = c_RAIL_NULL;
                        rail_c_d     = c_RAIL_NULL;
                        scomp_d      = 1'b1;
                        ccomp_d      = 1'b1;
                        state_d      = S_NULL;
                    end
                end else if (w_null_done) begin
                    scomp_d = 1'b0;
                    ccomp_d = 1'b0;
                    if (idx_q == c_LAST_IDX) begin
                        cout_d  = c_q;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d    = w_idx_nxt;
                        rail_a_d = enc(a_q[w_idx_nxt]);
                        rail_b_d = enc(b_q[w_idx_nxt]);
                        rail_c_d = enc(c_q);
                        state_d  = S_DATA;
                    end
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Phase timer restarts on every state entry, including DATA->NULL->DATA
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (w_timeout) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            sync_q   <= '0;
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rail_a_q <= c_RAIL_NULL;
            rail_b_q <= c_RAIL_NULL;
            rail_c_q <= c_RAIL_NULL;
            scomp_q  <= 1'b0;
            ccomp_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], w_ncl_raw};
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rail_a_q <= rail_a_d;
            rail_b_q <= rail_b_d;
            rail_c_q <= rail_c_d;
            scomp_q  <= scomp_d;
            ccomp_q  <= ccomp_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign sum_out       = sum_q;
    assign cout_out      = cout_q;
    assign error         = err_q;
    assign ncl.A         = rail_a_q;
    assign ncl.B         = rail_b_q;
    assign ncl.carryin   = rail_c_q;
    assign ncl.sumCOMP   = scomp_q;
    assign ncl.carryCOMP = ccomp_q;

endmodule
`default_nettype wire

// File: tb/tb_ncl_fulladd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ncl_fulladd_sequencer                                         |
// | Brief    : Sequencer against a random-delay NCL full-adder environment      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ncl_fulladd_sequencer;

    localparam int W      = 8;
    localparam int SS     = 2;
    localparam int TO2    = 16;
    localparam int MAXD   = 20;
    localparam int N_RAND = 150;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         init = 1'b0, init2 = 1'b0, start = 1'b0, start2 = 1'b0;
    logic         cin = 1'b0, cin2 = 1'b0;
    logic [W-1:0] a_in = '0, b_in = '0, a2 = '0, b2 = '0;
    logic         busy, done, cout_out, error, busy2, done2, cout2, error2;
    logic [W-1:0] sum_out, sum2;

    int vectors = 0;
    int miscompares = 0;

    ncl_fulladd_sequencer_if bus();
    ncl_fulladd_sequencer_if bus2();

    ncl_fulladd_sequencer #(.WIDTH(W), .SYNC_STAGES(SS), .TIMEOUT(255)) dut (
        .clk(clk), .init(init), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
        .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out), .error(error),
        .ncl(bus)
    );

    ncl_fulladd_sequencer #(.WIDTH(W), .SYNC_STAGES(SS), .TIMEOUT(TO2)) dut_to (
        .clk(clk), .init(init2), .start(start2), .a_in(a2), .b_in(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum_out(sum2), .cout_out(cout2), .error(error2),
        .ncl(bus2)
    );

    // Stalled adder: never acknowledges anything
    assign bus2.ABCOMP      = 1'b0;
    assign bus2.carryinCOMP = 1'b0;
    assign bus2.sum         = 2'b00;
    assign bus2.carryout    = 2'b00;

    // Adder model: outputs are {sum, carryout, ABCOMP, carryinCOMP}, each with its own delay
    logic [1:0] m_cur [4] = '{2'b00, 2'b00, 2'b00, 2'b00};
    int         m_cnt [4] = '{-1, -1, -1, -1};
    logic       force11 = 1'b0;
    logic       m_prev_data = 1'b0;
    int         m_wf = 0;
    int         inj_at = 0;

    assign bus.sum         = force11 ? 2'b11 : m_cur[0];
    assign bus.carryout    = m_cur[1];
    assign bus.ABCOMP      = m_cur[2][0];
    assign bus.carryinCOMP = m_cur[3][0];

    always @(negedge clk) begin : p_adder
        logic [1:0] tgt [4];
        logic       in_data, in_null;
        int         ones;
        in_data = (bus.A != 2'b00) && (bus.B != 2'b00) && (bus.carryin != 2'b00);
        in_null = (bus.A == 2'b00) && (bus.B == 2'b00) && (bus.carryin == 2'b00);
        ones = int'(bus.A == 2'b10) + int'(bus.B == 2'b10) + int'(bus.carryin == 2'b10);
        for (int i = 0; i < 4; i++) tgt[i] = m_cur[i];
        if (in_data) begin
            if (!bus.sumCOMP)   tgt[0] = ones[0] ? 2'b10 : 2'b01;
            if (!bus.carryCOMP) tgt[1] = (ones >= 2) ? 2'b10 : 2'b01;
            tgt[2] = 2'b01;
            tgt[3] = 2'b01;
        end else if (in_null) begin
            if (bus.sumCOMP)   tgt[0] = 2'b00;
            if (bus.carryCOMP) tgt[1] = 2'b00;
            tgt[2] = 2'b00;
            tgt[3] = 2'b00;
        end
        if (init) begin
            for (int i = 0; i < 4; i++) begin
                m_cur[i] = 2'b00;
                m_cnt[i] = -1;
            end
            force11     = 1'b0;
            m_prev_data = 1'b0;
        end else begin
            if (in_data && !m_prev_data) m_wf++;
            m_prev_data = in_data;
            if (inj_at != 0 && in_data && m_wf == inj_at) force11 = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (m_cur[i] == tgt[i])  m_cnt[i] = -1;
                else if (m_cnt[i] < 0)   m_cnt[i] = int'($urandom_range(0, MAXD));
                else if (m_cnt[i] == 0) begin
                    m_cur[i] = tgt[i];
                    m_cnt[i] = -1;
                end else                 m_cnt[i]--;
            end
        end
    end

    // Wavefront / rail-legality monitor on the main DUT
    int         data_wf = 0, null_wf = 0, done_cnt = 0;
    logic       bad_rail = 1'b0, dd_viol = 1'b0;
    logic [1:0] prev_a = 2'b00, prev_b = 2'b00, prev_c = 2'b00;

    always @(negedge clk) begin
        if (prev_a == 2'b00 && bus.A != 2'b00) data_wf++;
        if (prev_a != 2'b00 && bus.A == 2'b00) null_wf++;
        if (done) done_cnt++;
        if (bus.A == 2'b11 || bus.B == 2'b11 || bus.carryin == 2'b11) bad_rail = 1'b1;
        if ((prev_a != 2'b00 && bus.A != 2'b00 && bus.A != prev_a) ||
            (prev_b != 2'b00 && bus.B != 2'b00 && bus.B != prev_b) ||
            (prev_c != 2'b00 && bus.carryin != 2'b00 && bus.carryin != prev_c)) dd_viol = 1'b1;
        prev_a = bus.A;
        prev_b = bus.B;
        prev_c = bus.carryin;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input bit chk_waves);
        logic [W:0] exp;
        int d0, n0, dc0, k;
        exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        d0 = data_wf; n0 = null_wf; dc0 = done_cnt;
        a_in = a; b_in = b; cin = ci;
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        k = 0;
        while (!done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("sum_out", 32'(sum_out), 32'(exp[W-1:0]));
        check("cout_out", 32'(cout_out), 32'(exp[W]));
        check("busy_low_with_done", 32'(busy), 32'd0);
        @(negedge clk);
        if (chk_waves) begin
            check("done_pulses", 32'(done_cnt - dc0), 32'd1);
            check("data_wavefronts", 32'(data_wf - d0), 32'(W));
            check("null_wavefronts", 32'(null_wf - n0), 32'(W));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sum_out"}, 32'(sum_out), 32'd0);
        check({tag, "_cout"}, 32'(cout_out), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_rails"}, 32'({bus.A, bus.B, bus.carryin}), 32'd0);
        check({tag, "_comps"}, 32'({bus.sumCOMP, bus.carryCOMP}), 32'd0);
    endtask

    initial begin : p_watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        int k, n0, dc0;
        logic [W-1:0] ra, rb;
        #1;
        init = 1'b1;
        init2 = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        init = 1'b0;
        init2 = 1'b0;
        @(negedge clk);

        run_op(8'h5A, 8'h3C, 1'b0, 1'b1);
        run_op(8'hFF, 8'h01, 1'b0, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b1);

        for (int i = 0; i < N_RAND; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, 1'($urandom), 1'b0);
        end
        check("no_error_random", 32'(error), 32'd0);
        check("no_11_on_rails", 32'(bad_rail), 32'd0);
        check("no_data_to_data", 32'(dd_viol), 32'd0);

        // Corrupt sum rail during bit 3
        run_op(8'h00, 8'h00, 1'b0, 1'b0);
        dc0 = done_cnt;
        inj_at = m_wf + 4;
        a_in = 8'h0F; b_in = 8'h00; cin = 1'b0;
        pulse_start();
        k = 0;
        while (!error && k < 2000) begin
            @(negedge clk);
            k++;
        end
        inj_at = 0;
        repeat (3) @(negedge clk);
        check("inj_error", 32'(error), 32'd1);
        check("inj_sum_bit3_unwritten", 32'(sum_out), 32'h07);
        check("inj_no_done", 32'(done_cnt - dc0), 32'd0);
        check("inj_busy", 32'(busy), 32'd0);
        check("inj_rails_null", 32'({bus.A, bus.B, bus.carryin}), 32'd0);
        check("inj_comps_high", 32'({bus.sumCOMP, bus.carryCOMP}), 32'h3);
        pulse_start();
        @(negedge clk);
        check("inj_start_ignored", 32'({busy, bus.A}), 32'd0);

        init = 1'b1;
        repeat (2) @(negedge clk);
        init = 1'b0;
        @(negedge clk);
        check_reset_vals("init_clears_error");

        // Asynchronous init during the bit-5 NULL phase
        n0 = null_wf;
        a_in = 8'hAA; b_in = 8'h55; cin = 1'b1;
        pulse_start();
        k = 0;
        while (null_wf < n0 + 6 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("reached_bit5_null", 32'(null_wf - n0), 32'd6);
        #2 init = 1'b1;
        #1 check_reset_vals("async_init");
        repeat (2) @(negedge clk);
        init = 1'b0;
        @(negedge clk);
        run_op(8'h01, 8'h01, 1'b0, 1'b1);

        // Timeout on the stalled instance
        a2 = 8'h12; b2 = 8'h34; cin2 = 1'b0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("to_first_data_A", 32'(bus2.A), 32'h1);
        k = 1;
        while (!error2 && k < TO2 + SS + 1) begin
            @(negedge clk);
            k++;
        end
        check("to_error", 32'(error2), 32'd1);
        check("to_rails_null", 32'({bus2.A, bus2.B, bus2.carryin}), 32'd0);
        check("to_comps_high", 32'({bus2.sumCOMP, bus2.carryCOMP}), 32'h3);
        check("to_busy", 32'(busy2), 32'd0);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        check("to_start_ignored", 32'({busy2, bus2.A, done2}), 32'd0);
        check("to_error_sticky", 32'(error2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
